// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request plus doubleword address out, two words back.
// The fetch unit is the master; the instruction memory (or its model) is the slave.
interface instr_fetch_unit_if #(
  parameter int PCbitsize = 32
);
  logic                 imem_req;
  logic [PCbitsize-1:0] imem_addr;
  logic [31:0]          imem_rdata1;
  logic [31:0]          imem_rdata2;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata1,
    input  imem_rdata2
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata1,
    output imem_rdata2
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Dual-issue instruction fetch stage.
// Issues one doubleword read per cycle, buffers the returned instruction pairs in a
// small circular fetch queue and presents the head pair to the IF/ID register.
// A branch redirect flushes the queue, drops any in-flight response and restarts
// fetching at the target; a word-aligned (non-doubleword) target masks the first
// slot of the first returned pair with NOP_WORD.
module instr_fetch_unit #(
  parameter int                   PCbitsize = 32,
  parameter int                   QDEPTH    = 4,
  parameter logic [PCbitsize-1:0] RESET_PC  = '0,
  parameter logic [31:0]          NOP_WORD  = 32'h4020_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [PCbitsize-1:0] redirect_target,
  instr_fetch_unit_if.master   imem,
  output logic [PCbitsize-1:0] PC_adderOut,
  output logic [31:0]          instruction1,
  output logic [31:0]          instruction2,
  output logic                 pair_valid
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        QDEPTH_C   = CW'(QDEPTH);
  localparam logic [PCbitsize-1:0] PC_STEP    = PCbitsize'(8);
  localparam logic [PCbitsize-1:0] RESET_ADDR = {RESET_PC[PCbitsize-1:3], 3'b000};

  typedef struct packed {
    logic [PCbitsize-1:0] pair_pc;
    logic [31:0]          word1;
    logic [31:0]          word2;
    logic                 skip1;
  } entry_t;

  // Fetch-side state
  logic [PCbitsize-1:0] fetch_pc;
  logic [PCbitsize-1:0] inflight_pc;
  logic                 inflight;
  logic                 inflight_skip;
  logic                 pend_skip;

  // Fetch queue state
  entry_t               queue_mem [QDEPTH];
  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [PCbitsize-1:0] last_pc8;

  // Derived control
  logic [CW:0]          occupancy;
  logic                 req;
  logic                 enq;
  logic                 deq;
  logic                 empty;
  entry_t               head_entry;
  logic [PCbitsize-1:0] head_pc8;
  logic [PCbitsize-1:0] target_aligned;
  logic                 unused_target_bits;

  // Bits [1:0] of the redirect target never select anything: fetch is word-granular.
  assign unused_target_bits = ^redirect_target[1:0];
  assign target_aligned     = {redirect_target[PCbitsize-1:3], 3'b000};

  // Requests in flight count against the queue so that a returning response
  // always finds a free slot; a same-cycle dequeue earns no credit.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req       = reset_n && !redirect && (occupancy < {1'b0, QDEPTH_C});
  assign enq       = inflight && !redirect;
  assign empty     = (count == '0);
  assign deq       = pair_valid && !stall;

  assign head_entry = queue_mem[head];
  assign head_pc8   = head_entry.pair_pc + PC_STEP;

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  // Fetch PC, in-flight tracking and the pending-skip flag for unaligned targets.
  // NOTE: every register is written with <= so all flops sample the same pre-edge
  // values; a blocking = here would let later statements see half-updated state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc      <= RESET_ADDR;
      inflight_pc   <= '0;
      inflight      <= 1'b0;
      inflight_skip <= 1'b0;
      pend_skip     <= 1'b0;
    end else begin
      inflight      <= req;
      inflight_skip <= req && pend_skip;
      if (req) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc  <= target_aligned;
        pend_skip <= redirect_target[2];
      end else if (req) begin
        fetch_pc  <= fetch_pc + PC_STEP;
        pend_skip <= 1'b0;
      end
    end
  end

  // Queue pointers, occupancy and the PC+8 of the most recently consumed pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      last_pc8 <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + AW'(1);
      end
      if (deq) begin
        head     <= head + AW'(1);
        last_pc8 <= head_pc8;
      end
      unique case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: write the returning response at the tail.
  // NOTE: the storage array has no reset; count alone decides which entries are
  // live, so clearing the data would only add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (enq) begin
      queue_mem[tail] <= '{pair_pc: inflight_pc,
                           word1:   imem.imem_rdata1,
                           word2:   imem.imem_rdata2,
                           skip1:   inflight_skip};
    end
  end

  // Present the head pair, or NOP filler when empty or being flushed.
  // NOTE: every output gets a default first so no path through the block leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    pair_valid   = 1'b0;
    instruction1 = NOP_WORD;
    instruction2 = NOP_WORD;
    PC_adderOut  = last_pc8;
    if (!empty && !redirect) begin
      pair_valid   = 1'b1;
      instruction1 = head_entry.skip1 ? NOP_WORD : head_entry.word1;
      instruction2 = head_entry.word2;
      PC_adderOut  = head_pc8;
    end
  end

  // Occupancy can never exceed the queue depth because requests are credit-gated.
  assert property (@(posedge clk) disable iff (!reset_n) count <= QDEPTH_C)
    else $error("fetch queue occupancy exceeds depth");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Stimulus pushes the expected pair stream into a queue; a negedge monitor pops and
// compares every pair the DUT hands to decode. Timing points (latency, stall freeze,
// redirect bubbles, reset values, PC wrap) are checked directly in the stimulus.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h4020_0000;

  typedef struct {
    logic [31:0] pc8;
    logic [31:0] i1;
    logic [31:0] i2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: RESET_PC = 0x100
  logic        reset_n_a = 1'b0;
  logic        stall_a = 1'b0;
  logic        redirect_a = 1'b0;
  logic [31:0] target_a = '0;
  logic [31:0] pc_a, i1_a, i2_a;
  logic        pv_a;

  // DUT B: RESET_PC = 0xFFFF_FFF0 (wrap check)
  logic        reset_n_b = 1'b0;
  logic        stall_b = 1'b0;
  logic        redirect_b = 1'b0;
  logic [31:0] target_b = '0;
  logic [31:0] pc_b, i1_b, i2_b;
  logic        pv_b;

  instr_fetch_unit_if #(.PCbitsize(32)) bus_a ();
  instr_fetch_unit_if #(.PCbitsize(32)) bus_b ();

  instr_fetch_unit #(.PCbitsize(32), .QDEPTH(4), .RESET_PC(32'h0000_0100), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_target(target_a), .imem(bus_a.master),
    .PC_adderOut(pc_a), .instruction1(i1_a), .instruction2(i2_a), .pair_valid(pv_a));

  instr_fetch_unit #(.PCbitsize(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFF0), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_target(target_b), .imem(bus_b.master),
    .PC_adderOut(pc_b), .instruction1(i1_b), .instruction2(i2_b), .pair_valid(pv_b));

  // Memory models: word = address, one cycle after the request.
  always @(posedge clk) begin
    if (bus_a.imem_req) begin
      bus_a.imem_rdata1 <= bus_a.imem_addr;
      bus_a.imem_rdata2 <= bus_a.imem_addr + 32'd4;
    end
    if (bus_b.imem_req) begin
      bus_b.imem_rdata1 <= bus_b.imem_addr;
      bus_b.imem_rdata2 <= bus_b.imem_addr + 32'd4;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] last_pc8 = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(8 * i);
      exp_q.push_back('{pc8: a + 32'd8, i1: a, i2: a + 32'd4});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every pair accepted by decode must be the next expected one.
  always @(negedge clk) begin
    if (reset_n_a && pv_a && !stall_a) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pair: got pc8 %h, required no pair", pc_a);
      end else begin
        e = exp_q.pop_front();
        check("pair", {pc_a, i1_a, i2_a}, {e.pc8, e.i1, e.i2});
        last_pc8 = e.pc8;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_req",  {95'd0, bus_a.imem_req}, 96'd0);
    check("rst_pv",   {95'd0, pv_a}, 96'd0);
    check("rst_out",  {pc_a, i1_a, i2_a}, {32'd0, NOP, NOP});

    // Reset release and first-fetch latency
    push_seq(32'h100, 60);
    @(negedge clk);
    reset_n_a = 1'b1;
    #1;
    check("c0_req",  {63'd0, pv_a, bus_a.imem_req, bus_a.imem_addr}, {63'd0, 1'b0, 1'b1, 32'h100});
    tick();
    check("c1_req",  {63'd0, pv_a, bus_a.imem_req, bus_a.imem_addr}, {63'd0, 1'b0, 1'b1, 32'h108});
    tick();
    stall_a = 1'b1;
    check("c2_addr", {64'd0, bus_a.imem_addr}, {64'd0, 32'h110});

    // Stall for 10 cycles from C2: head frozen, requests stop at 4 credits
    for (int k = 0; k < 10; k++) begin
      check("stall_out", {pc_a, i1_a, i2_a}, {32'h108, 32'h100, 32'h104});
      check("stall_pv_req", {94'd0, pv_a, bus_a.imem_req}, {94'd0, 1'b1, (k < 2)});
      tick();
    end

    // Release: consecutive pairs, no gaps
    stall_a = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check("stream_pv", {95'd0, pv_a}, 96'd1);
      tick();
    end

    // Fill the queue, then redirect (with stall also high) to 0x2000
    stall_a = 1'b1;
    repeat (6) tick();
    check("full_pv", {95'd0, pv_a}, 96'd1);
    redirect_a = 1'b1;
    target_a   = 32'h2000;
    exp_q.delete();
    push_seq(32'h2000, 30);
    #1;
    check("r_out", {pc_a, i1_a, i2_a}, {last_pc8, NOP, NOP});
    check("r_pv_req", {94'd0, pv_a, bus_a.imem_req}, 96'd0);
    tick();
    redirect_a = 1'b0;
    stall_a    = 1'b0;
    #1;
    check("r1_req", {63'd0, pv_a, bus_a.imem_req, bus_a.imem_addr}, {63'd0, 1'b0, 1'b1, 32'h2000});
    check("r1_pc_hold", {64'd0, pc_a}, {64'd0, last_pc8});
    tick();
    check("r2_pv", {63'd0, pv_a, bus_a.imem_req, bus_a.imem_addr}, {63'd0, 1'b0, 1'b1, 32'h2008});
    tick();
    check("r3_pair", {63'd0, pv_a, pc_a}, {63'd0, 1'b1, 32'h2008});
    repeat (5) tick();

    // Redirect to a word-aligned target 0x2004
    redirect_a = 1'b1;
    target_a   = 32'h2004;
    exp_q.delete();
    exp_q.push_back('{pc8: 32'h2008, i1: NOP, i2: 32'h2004});
    push_seq(32'h2008, 30);
    #1;
    check("s_r_pv", {95'd0, pv_a}, 96'd0);
    tick();
    redirect_a = 1'b0;
    check("s_r1_addr", {64'd0, bus_a.imem_addr}, {64'd0, 32'h2000});
    tick();
    tick();
    check("s_first", {63'd0, pv_a, pc_a, i1_a, i2_a}, {31'd0, 1'b1, 32'h2008, NOP, 32'h2004});
    tick();
    check("s_second", {pc_a, i1_a, i2_a}, {32'h2010, 32'h2008, 32'h200C});
    repeat (3) tick();

    // Asynchronous reset mid-stream
    #2;
    reset_n_a = 1'b0;
    #1;
    check("mid_rst_out", {63'd0, pv_a, pc_a, i1_a, i2_a}, {32'd0, 32'd0, NOP, NOP});
    check("mid_rst_req", {95'd0, bus_a.imem_req}, 96'd0);
    exp_q.delete();
    push_seq(32'h100, 20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n_a = 1'b1;
    #1;
    check("rr_c0", {63'd0, pv_a, bus_a.imem_req, bus_a.imem_addr}, {63'd0, 1'b0, 1'b1, 32'h100});
    tick();
    check("rr_c1_pv", {95'd0, pv_a}, 96'd0);
    tick();
    check("rr_c2", {63'd0, pv_a, pc_a}, {63'd0, 1'b1, 32'h108});
    repeat (4) tick();

    // PC wrap on DUT B
    @(negedge clk);
    reset_n_b = 1'b1;
    #1;
    check("wrap_c0", {64'd0, bus_b.imem_addr}, {64'd0, 32'hFFFF_FFF0});
    tick();
    check("wrap_c1", {64'd0, bus_b.imem_addr}, {64'd0, 32'hFFFF_FFF8});
    tick();
    check("wrap_c2_addr", {64'd0, bus_b.imem_addr}, {64'd0, 32'h0000_0000});
    check("wrap_c2_pair", {63'd0, pv_b, pc_b, i1_b, i2_b}, {31'd0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'hFFFF_FFF4});
    tick();
    check("wrap_c3_pair", {pc_b, i1_b, i2_b}, {32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC});
    tick();
    check("wrap_c4_pair", {pc_b, i1_b, i2_b}, {32'h8, 32'h0, 32'h4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Dual-issue instruction fetch stage. Holds the fetch PC and issues doubleword-aligned reads of two 32-bit instructions per cycle to instruction memory. Responses are buffered in a small fetch queue, which decouples memory latency from decode stalls. Its outputs feed the IF/ID pipeline register directly: the pair PC+8 and two instruction words. It also accepts branch redirects from later stages.

## Interface
Parameters:
- PCbitsize, 32, width of all PC/address signals
- QDEPTH, 4, fetch queue depth in instruction pairs (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset (8-byte aligned)
- NOP_WORD, 32'h4020_0000, filler instruction word

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept a pair this cycle
- redirect  in  1  branch/flush request, single-cycle pulse
- redirect_target  in  PCbitsize  new fetch address, valid with redirect
- imem_req  out  1  read request this cycle
- imem_addr  out  PCbitsize  doubleword-aligned read address; bits [2:0] always 0
- imem_rdata1  in  32  word at imem_addr, valid the cycle after imem_req
- imem_rdata2  in  32  word at imem_addr+4, valid the cycle after imem_req
- PC_adderOut  out  PCbitsize  address of presented pair + 8
- instruction1  out  32  first instruction of presented pair
- instruction2  out  32  second instruction of presented pair
- pair_valid  out  1  presented pair is real (not filler)

## Operation
- fetch_pc register: on reset it is RESET_PC. Each cycle with imem_req=1, fetch_pc advances by 8, modulo 2^PCbitsize; wrap from all-ones-minus-7 to 0 is legal.
- imem_req = !redirect && (count + inflight < QDEPTH). Here count is the current queue occupancy, with no credit taken for a same-cycle dequeue. inflight is the registered request from the previous cycle. imem_addr = fetch_pc.
- Response capture: if inflight=1 and no redirect this cycle, the response is enqueued. Each entry holds {pair_pc, word1, word2, skip1}.
- skip1 is set only on the first pair fetched after a redirect whose target[2]=1. When skip1 is set, instruction1 is presented as NOP_WORD.
- Presentation is combinational from the queue head:
  - Queue non-empty and no redirect: pair_valid=1, PC_adderOut=pair_pc+8, and the head words are presented (with skip1 applied).
  - Otherwise: pair_valid=0, instruction1=instruction2=NOP_WORD, and PC_adderOut holds the last dequeued pair's PC+8 (0 after reset).
- Dequeue occurs when pair_valid && !stall.
- Redirect has priority over stall, enqueue and dequeue. On redirect:
  - The queue is flushed (count→0).
  - Any response arriving in the redirect cycle is dropped.
  - fetch_pc is set to {redirect_target[PCbitsize-1:3],3'b000}, and a pending-skip flag is set to redirect_target[2].
  - redirect_target[1:0] is ignored.
- The pending-skip flag is cleared once the first post-redirect request issues. That request's response is tagged skip1.
- Queue is a circular buffer with head/tail pointers of log2(QDEPTH) bits, plus a count of log2(QDEPTH)+1 bits. Full and empty states are distinguished by count. Enqueue and dequeue in the same cycle leave count unchanged.
- Overflow is impossible by construction. An assertion (count ≤ QDEPTH) is required.

## Timing
- Reset (async assert, value during reset_n=0):
  - imem_req=0; fetch_pc=RESET_PC; count=0; inflight=0.
  - pair_valid=0; instruction1/2=NOP_WORD; PC_adderOut=0.
- Reset deassertion: in the first clocked cycle C0, imem_req=1 and imem_addr=RESET_PC.
- Fetch latency: request in cycle C, data enqueued at the end of C+1, pair_valid=1 in C+2. Request-to-present latency is 2 cycles.
- Throughput: one pair per cycle sustained when stall=0.
- Stall: outputs hold the same head pair for every stalled cycle. Fetching continues until count+inflight reaches QDEPTH, then imem_req=0.
- Redirect in cycle R:
  - pair_valid=0 in R; no request in R.
  - Target request in R+1; target pair presented in R+3.
- Reset mid-operation discards the queue and any in-flight response immediately. No stale pair may appear after reset release.

## Test plan
- Reset release, RESET_PC=0x100, memory returns word = address, stall=0 → imem_addr 0x100,0x108,0x110…; from C2, PC_adderOut 0x108,0x110…, with instruction1/2 = 0x100/0x104, 0x108/0x10C…, and one pair_valid per cycle.
- Hold stall=1 from C2 for 10 cycles → outputs frozen at pair 0x100; imem_req drops after count+inflight=4. On release, pairs 0x100,0x108,0x110,0x118,0x120 appear consecutively with no gaps or duplicates.
- redirect with target 0x2000 while the queue is full → pair_valid=0 in R. Next valid pair appears in R+3 with PC_adderOut=0x2008. No pre-redirect pair is ever presented.
- redirect with target 0x2004 → first pair has instruction1=NOP_WORD, instruction2=0x2004, PC_adderOut=0x2008. The following pair is normal (0x2008/0x200C).
- redirect and stall both asserted in the same cycle → redirect honored; flush occurs and no dequeue happens.
- PC wrap: RESET_PC=0xFFFF_FFF0 → fetches 0xFFFF_FFF0, 0xFFFF_FFF8, then 0x0000_0000. Also assert reset_n mid-stream → outputs immediately show NOP, pair_valid=0, PC_adderOut=0.
